mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DataWidth, default 32, word width in bits.
REQ-002 Parameter AddrWidth, default 32, byte-address width.
REQ-003 Parameter Depth, default 1024, storage size in words; power of two.
REQ-004 Parameter Latency, default 4, cycles from request acceptance to first response beat; legal range 1..15.
REQ-005 Parameter BurstLen, default 4, beats per burst read (cache line refill); power of two, 2..16.
REQ-006 clk_i  input  1  single clock; all state updates on rising edge.
REQ-007 rst_ni  input  1  reset; asynchronous assertion, active-low.
REQ-008 req_valid_i  input  1  initiator (cache) presents a request.
REQ-009 req_ready_o  output  1  responder can accept a request this cycle.
REQ-010 req_we_i  input  1  1 = single-word write, 0 = read.
REQ-011 req_burst_i  input  1  read only: 1 = BurstLen-beat burst, 0 = single beat; ignored when req_we_i = 1.
REQ-012 req_addr_i  input  AddrWidth  byte address.
REQ-013 req_wdata_i  input  DataWidth  write data.
REQ-014 resp_valid_o  output  1  response beat present.
REQ-015 resp_ready_i  input  1  initiator accepts the beat.
REQ-016 resp_rdata_o  output  DataWidth  read data; 0 on write acknowledge.
REQ-017 resp_last_o  output  1  final beat of the transaction.

Function
REQ-018 Handshakes: request accepted on a rising edge with req_valid_i && req_ready_o; beat consumed on a rising edge with resp_valid_o && resp_ready_i.
REQ-019 Word index = req_addr_i[log2(Depth)+1:2]; bits [1:0] and bits above the index are ignored, so out-of-range addresses alias.
REQ-020 FSM states: IDLE, WAIT, XFER; reset state IDLE.
REQ-021 IDLE: req_ready_o = 1; on acceptance, load the latency counter with Latency-1 and go to WAIT; all other outputs 0.
REQ-022 Write: storage is updated at the acceptance edge. Read: data is sampled from storage when each beat is presented.
REQ-023 WAIT: req_ready_o = 0; decrement the counter each cycle; at 0 go to XFER, so the first beat is valid in cycle T+Latency for acceptance in cycle T.
REQ-024 XFER: resp_valid_o = 1; resp_rdata_o and resp_last_o hold stable until the beat is consumed.
REQ-025 Write and single reads use exactly one beat with resp_last_o = 1.
REQ-026 Burst read order is critical-word-first: beat k returns word ((start + k) mod BurstLen) within the BurstLen-aligned block; resp_last_o = 1 on beat BurstLen-1 only.
REQ-027 After a non-last beat is consumed, the next beat is valid in the following cycle; there are no bubbles while resp_ready_i = 1.
REQ-028 After the last beat is consumed, go to IDLE; req_ready_o = 1 in the next cycle. Back-to-back acceptance is therefore one cycle after the last beat.
REQ-029 Only one transaction is outstanding; req_* inputs are ignored outside IDLE.
REQ-030 resp_ready_i held low stalls XFER indefinitely with no data change; resp_ready_i in IDLE or WAIT has no effect.

Reset
REQ-031 rst_ni low asynchronously forces IDLE, counter 0, beat index 0, resp_valid_o = 0, resp_last_o = 0, resp_rdata_o = 0, req_ready_o = 0 while asserted.
REQ-032 Reset mid-transaction aborts it with no further beats; writes already accepted remain in storage.
REQ-033 Storage contents are not reset.
REQ-034 req_ready_o = 1 in the first cycle after rst_ni deasserts.

Structure
REQ-035 Package mem_pkg holds the FSM state enum (IDLE, WAIT, XFER) and the default parameter constants.
REQ-036 Storage is a sub-module mem_array: one write port, one asynchronous read port, no reset.
REQ-037 The FSM, latency counter and beat index live in mem_responder.

Verification
REQ-038 Write 0xDEADBEEF to 0x10, then single read of 0x10 -> each response arrives 4 cycles after acceptance; the read returns 0xDEADBEEF with resp_last_o = 1.
REQ-039 Preload words 0x20..0x2C with 0xA0..0xA3, burst read from 0x28 -> beats 0xA2, 0xA3, 0xA0, 0xA1 on consecutive cycles; resp_last_o set only on 0xA1.
REQ-040 Same burst with resp_ready_i low for 3 cycles on beat 1 -> 0xA3 is held stable; the sequence is unchanged with no dropped or repeated beats.
REQ-041 Request held valid during WAIT/XFER -> req_ready_o = 0, request is not accepted; it is accepted the cycle after the last beat.
REQ-042 Assert rst_ni low during WAIT of a read -> resp_valid_o = 0 immediately and no beat appears; post-reset read of earlier written data is unchanged.
REQ-043 Write 0x55 to address Depth*4 + 0x10 -> a read of 0x10 returns 0x55 (aliasing).

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: FSM state encoding and default parameters shared by the memory responder.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_e;
  localparam int DefDataWidth = 32;
  localparam int DefAddrWidth = 32;
  localparam int DefDepth = 1024;
  localparam int DefLatency = 4;
  localparam int DefBurstLen = 4;
endpackage

// File: rtl/mem_array.sv
// mem_array: word storage with one synchronous write port and one asynchronous read port, no reset.
module mem_array #(
  parameter int DataWidth = 32,
  parameter int Depth = 1024,
  localparam int IW = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [IW-1:0]        waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [IW-1:0]        raddr_i,
  output logic [DataWidth-1:0] rdata_o
);
  logic [DataWidth-1:0] mem_q [Depth];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with fixed latency and
// critical-word-first burst reads for cache refills.
module mem_responder import mem_pkg::*; #(
  parameter int DataWidth = DefDataWidth,
  parameter int AddrWidth = DefAddrWidth,
  parameter int Depth = DefDepth,
  parameter int Latency = DefLatency,
  parameter int BurstLen = DefBurstLen
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic                 req_burst_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DataWidth-1:0] resp_rdata_o,
  output logic                 resp_last_o
);
  localparam int IW = $clog2(Depth);
  localparam int BW = $clog2(BurstLen);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [IW-1:0] idx_q, idx_d, raddr;
  logic burst_q, burst_d, we_q, we_d, accept;
  logic [DataWidth-1:0] rd_data;
  logic unused_addr;
  assign unused_addr = ^{req_addr_i[AddrWidth-1:IW+2], req_addr_i[1:0]};
  assign req_ready_o = rst_ni && state_q == IDLE;
  assign accept = req_valid_i && req_ready_o;
  assign resp_valid_o = state_q == XFER;
  assign resp_last_o = resp_valid_o && (!burst_q || beat_q == BW'(BurstLen - 1));
  assign resp_rdata_o = (resp_valid_o && !we_q) ? rd_data : '0;
  // Beat offset wraps inside the aligned block; single reads keep beat 0.
  assign raddr = {idx_q[IW-1:BW], idx_q[BW-1:0] + beat_q};
  mem_array #(.DataWidth(DataWidth), .Depth(Depth)) u_mem (
    .clk_i   (clk_i),
    .we_i    (accept && req_we_i),
    .waddr_i (req_addr_i[IW+1:2]),
    .wdata_i (req_wdata_i),
    .raddr_i (raddr),
    .rdata_o (rd_data)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    beat_d = beat_q;
    idx_d = idx_q;
    burst_d = burst_q;
    we_d = we_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = (Latency == 1) ? XFER : WAIT;
        cnt_d = 4'(Latency - 1);
        idx_d = req_addr_i[IW+1:2];
        burst_d = req_burst_i && !req_we_i;
        we_d = req_we_i;
        beat_d = '0;
      end
      WAIT: begin
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        state_d = (cnt_q <= 4'd1) ? XFER : WAIT;
      end
      XFER: if (resp_ready_i) begin
        beat_d = resp_last_o ? '0 : beat_q + BW'(1);
        state_d = resp_last_o ? IDLE : XFER;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      beat_q <= '0;
      idx_q <= '0;
      burst_q <= 1'b0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      beat_q <= beat_d;
      idx_q <= idx_d;
      burst_q <= burst_d;
      we_q <= we_d;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench; stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_mem_responder;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, req_we = 0, req_burst = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic resp_valid, resp_ready = 1, resp_last;
  logic [31:0] resp_rdata;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [31:0] d; logic l; int c;} exp_t;
  exp_t sb[$];

  mem_responder dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_burst_i(req_burst), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .resp_last_o(resp_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) chk("unexpected_beat", 32'(resp_valid), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("beat_data", resp_rdata, e.d);
        chk("beat_last", 32'(resp_last), 32'(e.l));
        if (e.c >= 0) chk("beat_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  task automatic push(input logic [31:0] d, input logic l, input int c);
    exp_t e;
    e.d = d; e.l = l; e.c = c;
    sb.push_back(e);
  endtask

  task automatic wait_acc(output int acc);
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic we, input logic burst, input logic [31:0] addr,
                        input logic [31:0] wdata, output int acc);
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_burst = burst; req_addr = addr; req_wdata = wdata;
    wait_acc(acc);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic drain();
    int done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !resp_valid) begin
        done = 1;
        break;
      end
    end
    if (done == 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int acc, acc2;
    logic [31:0] a3;
    a3 = 32'hA3;
    #3;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_last", 32'(resp_last), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    do_req(1, 0, 32'h10, 32'hDEADBEEF, acc);
    push(32'h0, 1, acc + 4);
    drain();
    do_req(0, 0, 32'h10, 0, acc);
    push(32'hDEADBEEF, 1, acc + 4);
    drain();

    for (int k = 0; k < 4; k++) begin
      do_req(1, 0, 32'h20 + 32'(4 * k), 32'hA0 + 32'(k), acc);
      push(32'h0, 1, acc + 4);
      drain();
    end

    do_req(0, 1, 32'h28, 0, acc);
    push(32'hA2, 0, acc + 4);
    push(32'hA3, 0, acc + 5);
    push(32'hA0, 0, acc + 6);
    push(32'hA1, 1, acc + 7);
    drain();

    do_req(0, 1, 32'h28, 0, acc);
    push(32'hA2, 0, acc + 4);
    push(32'hA3, 0, -1);
    push(32'hA0, 0, -1);
    push(32'hA1, 1, -1);
    while (cyc < acc + 4) @(negedge clk);
    @(posedge clk); #1;
    resp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_data", resp_rdata, a3);
      chk("stall_last", 32'(resp_last), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1;
    drain();

    @(posedge clk); #1;
    req_valid = 1; req_we = 0; req_burst = 0; req_addr = 32'h10;
    wait_acc(acc);
    push(32'hDEADBEEF, 1, acc + 4);
    @(posedge clk); #1;
    req_addr = 32'h24;
    wait_acc(acc2);
    chk("b2b_accept_cycle", 32'(acc2), 32'(acc + 5));
    @(posedge clk); #1;
    req_valid = 0;
    push(32'hA1, 1, acc2 + 4);
    drain();

    do_req(0, 0, 32'h10, 0, acc);
    rst_n = 0;
    #1;
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_abort", 32'(req_ready), 32'd1);
    do_req(0, 0, 32'h10, 0, acc);
    push(32'hDEADBEEF, 1, acc + 4);
    drain();

    do_req(1, 0, 32'(1024 * 4 + 32'h10), 32'h55, acc);
    push(32'h0, 1, acc + 4);
    drain();
    do_req(0, 0, 32'h10, 0, acc);
    push(32'h55, 1, acc + 4);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end
endmodule
